// File: rtl/pipelined_riscv_cpu_pkg.sv
// Shared encodings, pipeline register layouts and the instruction decoder
// for the five-stage RV32 subset core.
package pipelined_riscv_cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;  // add/sub/mul/addi
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;  // lw/sw
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRA  = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // sub/srai
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_SLL  = 3'd4,
    ALU_SRA  = 3'd5,
    ALU_MUL  = 3'd6,
    ALU_ZERO = 3'd7
  } aluctl_e;

  typedef struct packed {
    logic   reg_write;
    logic   mem_to_reg;
    logic   mem_read;
    logic   mem_write;
    aluop_e alu_op;
    logic   alu_src;
    logic   branch;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    aluop_e      alu_op;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
  } mem_wb_t;

  // Anything not in the supported subset decodes to all-zero control,
  // so it travels down the pipe as a bubble.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t      c;
    logic [2:0] f3;
    logic [6:0] f7;
    c  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (instr[6:0])
      OP_R: begin
        if ((f7 == F7_BASE && (f3 inside {F3_ADD, F3_SLL, F3_XOR, F3_AND})) ||
            ((f7 == F7_ALT || f7 == F7_MUL) && f3 == F3_ADD)) begin
          c.reg_write = 1'b1;
          c.alu_op    = ALUOP_RTYPE;
        end
      end
      OP_I: begin
        if (f3 == F3_ADD || (f3 == F3_SRA && f7 == F7_ALT)) begin
          c.reg_write = 1'b1;
          c.alu_op    = ALUOP_ITYPE;
          c.alu_src   = 1'b1;
        end
      end
      OP_LOAD: begin
        if (f3 == F3_WORD) begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.mem_read   = 1'b1;
          c.alu_src    = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == F3_WORD) begin
          c.mem_write = 1'b1;
          c.alu_src   = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (f3 == F3_BEQ) begin
          c.branch = 1'b1;
          c.alu_op = ALUOP_BRANCH;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_riscv_cpu_alu.sv
// ALU control decode plus the datapath ALU used in the EX stage.
module pipelined_riscv_cpu_alu
  import pipelined_riscv_cpu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  aluctl_e alu_control;

  // Map ALUOp and the function fields onto a single ALU operation
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop_e'(alu_op))
      ALUOP_MEM:    alu_control = ALU_ADD;
      ALUOP_BRANCH: alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD:  alu_control = (funct7 == F7_MUL) ? ALU_MUL :
                                 (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_control = ALU_SLL;
          F3_XOR:  alu_control = ALU_XOR;
          F3_AND:  alu_control = ALU_AND;
          default: alu_control = ALU_ZERO;
        endcase
      end
      ALUOP_ITYPE:  alu_control = (funct3 == F3_SRA) ? ALU_SRA : ALU_ADD;
      default:      alu_control = ALU_ZERO;
    endcase
  end

  // Shifts take their amount from the low five bits of b (shamt for srai)
  always_comb begin
    y = '0;
    case (alu_control)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
      ALU_MUL: y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_riscv_cpu.sv
// Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB) with load-use
// stall, EX forwarding and beq resolved in ID.
module pipelined_riscv_cpu
  import pipelined_riscv_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  // Storage is never reset; contents are preloaded from outside.
  logic [31:0] instruction_memory [IMEM_WORDS];
  logic [31:0] data_memory        [DMEM_WORDS];
  logic [31:0] registers          [32];

  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  logic [31:0] wb_data;

  // ---------------- ID ----------------
  logic [4:0]  id_rs1, id_rs2, id_rd;
  ctrl_t       control;
  logic [31:0] id_rd1, id_rd2, id_imm, id_immb, br_target;
  logic        stall, flush, br_taken, hold;

  assign id_rs1  = if_id.instr[19:15];
  assign id_rs2  = if_id.instr[24:20];
  assign id_rd   = if_id.instr[11:7];
  assign control = decode(if_id.instr);

  // I-type immediate everywhere except stores; immB is the halfword offset
  assign id_imm  = (if_id.instr[6:0] == OP_STORE) ?
                   {{20{if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]} :
                   {{20{if_id.instr[31]}}, if_id.instr[31:20]};
  assign id_immb = {{20{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                    if_id.instr[30:25], if_id.instr[11:8]};
  assign br_target = if_id.pc + (id_immb << 1);

  // Register-file read; a same-cycle WB write to the source reads through
  always_comb begin
    id_rd1 = (id_rs1 == 5'd0) ? '0 : registers[id_rs1];
    id_rd2 = (id_rs2 == 5'd0) ? '0 : registers[id_rs2];
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_rs1) id_rd1 = wb_data;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_rs2) id_rd2 = wb_data;
  end

  // Load-use hazard against the instruction currently in EX
  assign stall = id_ex.mem_read && id_ex.rd != 5'd0 &&
                 (id_ex.rd == id_rs1 || id_ex.rd == id_rs2);

  // beq compares raw register-file values; a stall defers the decision
  assign br_taken = control.branch && (id_rd1 == id_rd2);
  assign flush    = br_taken && !stall && start_i;

  // With start low the front end freezes like a stall so the instruction
  // sitting in ID is neither lost nor issued twice; later stages drain.
  assign hold = stall || !start_i;

  // ---------------- IF ----------------
  // PC advances only while running and not stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  pc <= '0;
    else if (start_i && !stall) pc <= flush ? br_target : pc + 32'd4;
  end

  // IF/ID: squashed on a taken branch, frozen while holding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) if_id <= '0;
    else if (flush) if_id <= '0;
    else if (!hold) begin
      if_id.pc    <= pc;
      if_id.instr <= instruction_memory[pc[IAW+1:2]];
    end
  end

  // ID/EX: a hold injects a bubble with all control cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) id_ex <= '0;
    else if (hold) id_ex <= '0;
    else begin
      id_ex.reg_write  <= control.reg_write;
      id_ex.mem_to_reg <= control.mem_to_reg;
      id_ex.mem_read   <= control.mem_read;
      id_ex.mem_write  <= control.mem_write;
      id_ex.alu_op     <= control.alu_op;
      id_ex.alu_src    <= control.alu_src;
      id_ex.rd1        <= id_rd1;
      id_ex.rd2        <= id_rd2;
      id_ex.imm        <= id_imm;
      id_ex.rs1        <= id_rs1;
      id_ex.rs2        <= id_rs2;
      id_ex.rd         <= id_rd;
      id_ex.funct3     <= if_id.instr[14:12];
      id_ex.funct7     <= if_id.instr[31:25];
    end
  end

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;

  // Forwarding: the younger EX/MEM result overrides MEM/WB
  always_comb begin
    fwd_a = id_ex.rd1;
    fwd_b = id_ex.rd2;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1) fwd_a = wb_data;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2) fwd_b = wb_data;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1) fwd_a = ex_mem.alu_result;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2) fwd_b = ex_mem.alu_result;
  end

  assign alu_b = id_ex.alu_src ? id_ex.imm : fwd_b;

  pipelined_riscv_cpu_alu alu (
    .alu_op (id_ex.alu_op),
    .funct3 (id_ex.funct3),
    .funct7 (id_ex.funct7),
    .a      (fwd_a),
    .b      (alu_b),
    .y      (alu_y)
  );

  // EX/MEM: store data is the forwarded rs2 value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ex_mem <= '0;
    else begin
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_to_reg <= id_ex.mem_to_reg;
      ex_mem.mem_write  <= id_ex.mem_write;
      ex_mem.alu_result <= alu_y;
      ex_mem.store_data <= fwd_b;
      ex_mem.rd         <= id_ex.rd;
    end
  end

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;
  assign mem_rdata = data_memory[ex_mem.alu_result[DAW+1:2]];

  // Data memory write port
  always_ff @(posedge clk_i) begin
    if (ex_mem.mem_write) data_memory[ex_mem.alu_result[DAW+1:2]] <= ex_mem.store_data;
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_wb <= '0;
    else begin
      mem_wb.reg_write  <= ex_mem.reg_write;
      mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
      mem_wb.alu_result <= ex_mem.alu_result;
      mem_wb.mem_data   <= mem_rdata;
      mem_wb.rd         <= ex_mem.rd;
    end
  end

  // ---------------- WB ----------------
  assign wb_data = mem_wb.mem_to_reg ? mem_wb.mem_data : mem_wb.alu_result;

  // Register-file write; x0 is never written
  always_ff @(posedge clk_i) begin
    if (mem_wb.reg_write && mem_wb.rd != 5'd0) registers[mem_wb.rd] <= wb_data;
  end

endmodule

// File: tb/tb_pipelined_riscv_cpu.sv
// Directed programs for the pipelined core; an ISA-level interpreter gives
// the expected architectural state, stall count and flush count.
module tb_pipelined_riscv_cpu;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011,
                         OPS = 7'b0100011, OPB = 7'b1100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  pipelined_riscv_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int stall_cnt = 0, flush_cnt = 0;
  int m_stalls, m_flushes;
  logic [31:0] m_imem [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_mem  [32];

  // Running tallies of stall and flush cycles
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.stall) stall_cnt++;
      if (dut.flush) flush_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction
  function automatic logic [31:0] i_t(input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, OPI};
  endfunction
  function automatic logic [31:0] lw_t(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, OPL};
  endfunction
  function automatic logic [31:0] sw_t(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPS};
  endfunction
  function automatic logic [31:0] beq_t(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], OPB};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 256; i++) m_imem[i] = '0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_mem[i] = '0; end
  endtask

  // Sequential ISA interpreter; also counts load-use pairs and taken beqs
  task automatic model_run(input int n_words);
    logic [31:0] pc, ins, a, b, res, nxt, immi, imms, boff, addr, nx;
    logic wr;
    pc = '0; m_stalls = 0; m_flushes = 0;
    for (int steps = 0; steps < 200 && pc < n_words * 4; steps++) begin
      ins  = m_imem[pc[9:2]];
      a    = m_reg[ins[19:15]];
      b    = m_reg[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      boff = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      nxt  = pc + 4; wr = 1'b0; res = '0;
      case (ins[6:0])
        OPR: begin
          wr = 1'b1;
          case ({ins[31:25], ins[14:12]})
            {7'h00, 3'b000}: res = a + b;
            {7'h20, 3'b000}: res = a - b;
            {7'h01, 3'b000}: res = a * b;
            {7'h00, 3'b111}: res = a & b;
            {7'h00, 3'b100}: res = a ^ b;
            {7'h00, 3'b001}: res = a << b[4:0];
            default: wr = 1'b0;
          endcase
        end
        OPI: begin
          if (ins[14:12] == 3'b000) begin wr = 1'b1; res = a + immi; end
          else if (ins[14:12] == 3'b101 && ins[31:25] == 7'h20) begin
            wr = 1'b1; res = $signed(a) >>> ins[24:20];
          end
        end
        OPL: if (ins[14:12] == 3'b010) begin addr = a + immi; wr = 1'b1; res = m_mem[addr[6:2]]; end
        OPS: if (ins[14:12] == 3'b010) begin addr = a + imms; m_mem[addr[6:2]] = b; end
        OPB: if (ins[14:12] == 3'b000 && a == b) begin nxt = pc + boff; m_flushes++; end
        default: ;
      endcase
      if (wr && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
      if (ins[6:0] == OPL && ins[14:12] == 3'b010 && ins[11:7] != 5'd0) begin
        nx = m_imem[nxt[9:2]];
        if (nx[19:15] == ins[11:7] || nx[24:20] == ins[11:7]) m_stalls++;
      end
      pc = nxt;
    end
  endtask

  // Copy the initial image into the DUT (reset held), then run the model
  task automatic load_and_model(input int n_words);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.instruction_memory[i] = m_imem[i];
    for (int i = 0; i < 32; i++) begin dut.registers[i] = m_reg[i]; dut.data_memory[i] = m_mem[i]; end
    model_run(n_words);
  endtask

  task automatic compare_state(input string tag);
    for (int r = 1; r < 32; r++)
      check($sformatf("%s x%0d", tag, r), dut.registers[r], m_reg[r]);
    for (int w = 0; w < 32; w++)
      check($sformatf("%s dmem[%0d]", tag, w), dut.data_memory[w], m_mem[w]);
  endtask

  task automatic run_prog(input string tag, input int n_words);
    int s0, f0;
    load_and_model(n_words);
    s0 = stall_cnt; f0 = flush_cnt;
    rst = 1'b0; start = 1'b1;
    repeat (n_words + 12) @(negedge clk);
    start = 1'b0;
    compare_state(tag);
    check({tag, " stalls"},  stall_cnt - s0, m_stalls);
    check({tag, " flushes"}, flush_cnt - f0, m_flushes);
  endtask

  initial begin
    int s0, f0;
    repeat (2) @(negedge clk);
    check("reset pc", dut.pc, 32'd0);
    check("reset if_id instr", dut.if_id.instr, 32'd0);

    // load-use
    clear_all();
    m_mem[0] = 32'd5;
    m_imem[0] = lw_t(1, 0, 0);
    m_imem[1] = r_t(7'h00, 3'b000, 2, 1, 1);
    run_prog("loaduse", 2);
    check("loaduse model x2", m_reg[2], 32'd10);
    check("loaduse x1", dut.registers[1], 32'd5);
    check("loaduse x2", dut.registers[2], 32'd10);
    check("loaduse model stalls", m_stalls, 32'd1);

    // forwarding
    clear_all();
    m_imem[0] = i_t(3'b000, 1, 0, 12'd3);
    m_imem[1] = i_t(3'b000, 2, 1, 12'd4);
    m_imem[2] = r_t(7'h00, 3'b000, 3, 2, 1);
    run_prog("fwd", 3);
    check("fwd x2", dut.registers[2], 32'd7);
    check("fwd x3", dut.registers[3], 32'd10);

    // taken branch
    clear_all();
    m_imem[0] = beq_t(1, 2, 13'd8);
    m_imem[1] = i_t(3'b000, 3, 0, 12'd1);
    m_imem[2] = i_t(3'b000, 4, 0, 12'd2);
    run_prog("taken", 3);
    check("taken x3", dut.registers[3], 32'd0);
    check("taken x4", dut.registers[4], 32'd2);
    check("taken model flushes", m_flushes, 32'd1);

    // not-taken branch
    clear_all();
    m_reg[1] = 32'd1;
    m_imem[0] = beq_t(1, 0, 13'd8);
    m_imem[1] = i_t(3'b000, 3, 0, 12'd1);
    run_prog("nottaken", 2);
    check("nottaken x3", dut.registers[3], 32'd1);

    // store / shift / mul
    clear_all();
    m_imem[0] = i_t(3'b000, 5, 0, 12'hff0);
    m_imem[1] = i_t(3'b101, 6, 5, 12'h402);
    m_imem[2] = r_t(7'h01, 3'b000, 7, 6, 6);
    m_imem[3] = sw_t(7, 0, 12'd4);
    run_prog("smul", 4);
    check("smul x6", dut.registers[6], 32'hfffffffc);
    check("smul x7", dut.registers[7], 32'd16);
    check("smul mem[1]", dut.data_memory[1], 32'd16);
    check("smul model mem[1]", m_mem[1], 32'd16);

    // logic ops, unsupported encoding, rs2 load-use, load to x0
    clear_all();
    m_reg[1] = 32'h0f0f; m_reg[2] = 32'h00ff; m_mem[2] = 32'd77;
    m_imem[0] = r_t(7'h00, 3'b111, 3, 1, 2);
    m_imem[1] = r_t(7'h00, 3'b100, 4, 1, 2);
    m_imem[2] = i_t(3'b000, 6, 0, 12'd4);
    m_imem[3] = r_t(7'h00, 3'b001, 5, 2, 6);
    m_imem[4] = r_t(7'h20, 3'b000, 7, 2, 1);
    m_imem[5] = r_t(7'h00, 3'b110, 8, 1, 2);
    m_imem[6] = lw_t(9, 0, 12'd8);
    m_imem[7] = r_t(7'h00, 3'b000, 10, 0, 9);
    m_imem[8] = lw_t(0, 0, 12'd8);
    m_imem[9] = r_t(7'h00, 3'b000, 11, 0, 0);
    run_prog("mix", 10);
    check("mix x3", dut.registers[3], 32'h0000000f);
    check("mix x4", dut.registers[4], 32'h00000ff0);
    check("mix x5", dut.registers[5], 32'h00000ff0);
    check("mix x7", dut.registers[7], 32'hfffff1f0);
    check("mix x8", dut.registers[8], 32'd0);
    check("mix x10", dut.registers[10], 32'd77);
    check("mix model x7", m_reg[7], 32'hfffff1f0);

    // reset mid-run and start gating
    clear_all();
    for (int k = 0; k < 6; k++) m_imem[k] = i_t(3'b000, 5'(k + 1), 0, 12'(11 * (k + 1)));
    load_and_model(6);
    s0 = stall_cnt; f0 = flush_cnt;
    rst = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async reset pc", dut.pc, 32'd0);
    check("async reset if_id", dut.if_id.instr, 32'd0);
    repeat (2) @(negedge clk);
    for (int r = 1; r <= 6; r++) check($sformatf("rst no write x%0d", r), dut.registers[r], 32'd0);
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("idle pc c%0d", c), dut.pc, 32'd0);
    end
    check("idle x1", dut.registers[1], 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("run pc", dut.pc, 32'd12);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("paused pc c%0d", c), dut.pc, 32'd12);
    end
    start = 1'b1;
    repeat (16) @(negedge clk);
    start = 1'b0;
    compare_state("restart");
    check("restart x6", dut.registers[6], 32'd66);
    check("restart stalls", stall_cnt - s0, m_stalls);
    check("restart flushes", flush_cnt - f0, m_flushes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
